// File: rtl/block_mem_pkg.sv
// Shared definitions for the block memory stage: operation codes, controller
// states, block geometry and address field positions.
package block_mem_pkg;

    localparam int BLOCK_WORDS = 4;
    localparam int WORD_W      = 32;
    localparam int BLOCK_W     = 128;
    localparam int ADDR_W      = 10;

    // Byte-address fields: offset inside a 16-byte block, and block index.
    localparam int OFF_LSB = 0;
    localparam int OFF_MSB = 3;
    localparam int IDX_LSB = 4;
    localparam int IDX_MSB = 9;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_WB_FILL = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WB     = 2'b01,
        ST_ACCESS = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    // Block index of a byte address; the in-block offset is dropped.
    function automatic logic [IDX_W-1:0] block_idx(input logic [ADDR_W-1:0] a);
        return a[IDX_MSB:IDX_LSB];
    endfunction

endpackage

// File: rtl/block_mem_array.sv
// Word-organised backing store with a synchronous whole-block write port and
// a combinational whole-block read port. Word 0 of a block sits in the top
// 32 bits of the block bus.
module block_mem_array
    import block_mem_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [BLOCK_W-1:0] wdata,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [BLOCK_W-1:0] rdata
);

    // Contents start at zero and are deliberately not touched by reset.
    logic [WORD_W-1:0] mem_r [MEM_WORDS] = '{default: 32'h0000_0000};

    // Commit all four words of a block on the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                mem_r[{wr_idx, 2'(i)}] <= wdata[BLOCK_W-1-WORD_W*i -: WORD_W];
            end
        end
    end

    for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_rd
        assign rdata[BLOCK_W-1-WORD_W*g -: WORD_W] = mem_r[{rd_idx, 2'(g)}];
    end

endmodule

// File: rtl/block_mem_ctrl.sv
// Main-memory stage behind the write-back cache. Services whole-block READ,
// WRITE and combined write-back-then-fill requests over a req/done handshake,
// spending LATENCY cycles in each memory phase.
module block_mem_ctrl
    import block_mem_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic [1:0]         op,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [ADDR_W-1:0]  victim_addr,
    input  logic [BLOCK_W-1:0] wd,
    output logic [BLOCK_W-1:0] rd,
    output logic               done,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);

    state_e             state_r;
    state_e             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;

    op_e                op_r;
    logic [IDX_W-1:0]   addr_idx_r;
    logic [IDX_W-1:0]   victim_idx_r;
    logic [BLOCK_W-1:0] wd_r;

    logic [BLOCK_W-1:0] rd_r;
    logic               done_r;
    logic               busy_r;

    logic               accept_s;
    logic               mem_we_s;
    logic [IDX_W-1:0]   mem_wr_idx_s;
    logic               rd_load_s;
    logic [BLOCK_W-1:0] mem_rdata_s;

    // Byte offsets inside a block carry no meaning for whole-block transfers.
    logic               unused_offset_s;
    assign unused_offset_s = ^{addr[OFF_MSB:OFF_LSB], victim_addr[OFF_MSB:OFF_LSB]};

    block_mem_array #(
        .MEM_WORDS (MEM_WORDS)
    ) u_array (
        .clk    (clk),
        .we     (mem_we_s),
        .wr_idx (mem_wr_idx_s),
        .wdata  (wd_r),
        .rd_idx (addr_idx_r),
        .rdata  (mem_rdata_s)
    );

    // Next-state, phase counter and array/readback strobes.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        mem_we_s     = 1'b0;
        mem_wr_idx_s = addr_idx_r;
        rd_load_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    accept_s     = 1'b1;
                    cnt_next_s   = CNT_RELOAD;
                    state_next_s = (op_e'(op) == OP_WB_FILL) ? ST_WB : ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WB: begin
                if (cnt_r == 4'd0) begin
                    // Victim goes out first so a same-block fill sees it.
                    mem_we_s     = 1'b1;
                    mem_wr_idx_s = victim_idx_r;
                    cnt_next_s   = CNT_RELOAD;
                    state_next_s = ST_ACCESS;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == 4'd0) begin
                    if (op_r == OP_WRITE) begin
                        mem_we_s = 1'b1;
                    end else begin
                        // READ, WB_FILL and the reserved code all read back.
                        rd_load_s = 1'b1;
                    end
                    state_next_s = ST_DONE;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and the registered done/busy flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            done_r  <= (state_next_s == ST_DONE);
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Request capture; inputs are free to change once a request is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r         <= OP_READ;
            addr_idx_r   <= 6'd0;
            victim_idx_r <= 6'd0;
            wd_r         <= 128'd0;
        end else if (accept_s) begin
            op_r         <= op_e'(op);
            addr_idx_r   <= block_idx(addr);
            victim_idx_r <= block_idx(victim_addr);
            wd_r         <= wd;
        end else begin
            op_r         <= op_r;
            addr_idx_r   <= addr_idx_r;
            victim_idx_r <= victim_idx_r;
            wd_r         <= wd_r;
        end
    end

    // Read data register; holds until the next read-type completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_r <= 128'd0;
        end else if (rd_load_s) begin
            rd_r <= mem_rdata_s;
        end else begin
            rd_r <= rd_r;
        end
    end

    assign rd   = rd_r;
    assign done = done_r;
    assign busy = busy_r;

endmodule
